// File: rtl/dmem_if.sv
// Load/store port between the core's MEM stage and a data memory.
// The master drives requests and the slave returns one response per request.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle word memory for the core's load/store port: one request at a time,
// byte-lane stores, response after WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic          ready_int;
    logic          accept;
    logic          do_access;
    logic          acc_write;
    logic          acc_err;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;

    assign ready_int = (state_q == S_IDLE) && !reset;
    assign accept    = bus.req_valid && ready_int;

    // The access uses live request inputs only for the zero-wait accept edge.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_write = bus.req_write;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            acc_be    = bus.req_be;
        end else begin
            acc_write = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
        acc_idx = acc_addr[AW+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) ||
                  (acc_addr[31:AW+2] != BASE_ADDR[31:AW+2]);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wr_d    = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    do_access = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (!acc_write && !acc_err) ? mem_q[acc_idx] : '0;
        end
    end

    always_comb begin
        bus.req_ready = ready_int;
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_err   = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    // Storage is never reset; a reset on the access edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (do_access && !reset && acc_write && !acc_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined RV32 core's load/store port.
- Accepts one word-sized request at a time over a valid/ready handshake and applies byte-lane writes to internal word storage.
- Returns one response per request after a fixed, parameterised number of wait states.
- Lets the core's MEM stage be tested against a multi-cycle memory with backpressure, in place of an ideal single-cycle array.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words stored; power of two, at least 2.
- BASE_ADDR, 32'h0000_2000, byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_CYCLES, 2, wait states inserted between accept and response; range 0..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte enables; bit i selects bits 8i+7:8i
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts the response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or out of range

Behaviour:
- Reset (sampled at a rising edge while reset=1):
  - State goes to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=0 during any cycle in which reset=1.
  - Storage contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- req_ready = 1 only in IDLE with reset=0. A request is accepted on an edge where req_valid & req_ready = 1. At accept, req_write, req_addr, req_wdata and req_be are latched.
- Accept transition:
  - WAIT_CYCLES=0: perform the access on the accepting edge and go to RESP.
  - Otherwise: load a 4-bit counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: when the counter is 0, perform the access and go to RESP; otherwise decrement the counter.
- Latency: if the accept cycle is cycle 0, rsp_valid is first high in cycle WAIT_CYCLES+1.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - On an edge with rsp_valid & rsp_ready, go to IDLE, rsp_valid→0 and rsp_rdata→0.
  - There is no same-edge back-to-back accept; the next accept is possible one cycle later at the earliest.
- Access and error rules:
  - Error condition: req_addr[1:0] != 0, or req_addr outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).
  - On error: no storage access, rsp_err=1, rsp_rdata=0. Latency is unchanged.
  - Word index = (req_addr - BASE_ADDR) >> 2, width log2(DEPTH_WORDS).
- Store: only lanes with req_be[i]=1 are written; other lanes keep their value. req_be=0 is a legal no-op store with rsp_err=0. rsp_rdata=0.
- Load: returns the full stored word, ignoring req_be.
- Write commit point: storage is updated only at the access edge.
  - If reset occurs at or before that edge, the store is not committed.
  - If reset occurs after it (in RESP), the store stays committed and the response is dropped.
- Inputs are ignored outside IDLE; req_valid may stay high.

Test Plan:
- Aligned store then load: store addr 0x2004, wdata 0xDEADBEEF, be 4'hF, WAIT_CYCLES=2. Store accepted in cycle 0 → rsp_valid in cycle 3 with err=0, rdata=0. Subsequent load of 0x2004 → rdata 0xDEADBEEF, err=0.
- Partial store: after the above, store wdata 0x11223344 with be 4'b0101 to 0x2004 → a later load returns 0xDE22BE44.
- Errors: load 0x2006 → err=1, rdata=0. Store 0x0000_3000 (DEPTH_WORDS=1024, so out of range) → err=1, and a subsequent load of 0x2000 returns its prior value. rsp_valid timing in both cases equals the normal latency.
- Backpressure: hold rsp_ready=0 for 3 cycles during RESP → rsp_valid, rdata and err stay constant and req_ready stays 0. Raise rsp_ready → IDLE next cycle, req_ready=1.
- Reset mid-operation: store 0x2008 with 0xCAFEF00D and pulse reset during WAIT → rsp_valid never asserts for that request. A later load of 0x2008 returns the old value.
- WAIT_CYCLES=0 build: with rsp_ready held high and req_valid held high, four consecutive loads → rsp_valid in cycle 1 after each accept and one accept every 2 cycles.
